// File: rtl/bsg_cache_nb_mgmt_dma.sv
// DMA engine for the non-blocking cache management unit: issues line request packets,
// streams evicted lines out of data_mem and writes refill lines into it, one word per beat.
module bsg_cache_nb_mgmt_dma #(
   parameter int unsigned addr_width_p          = 32,
   parameter int unsigned word_width_p          = 32,
   parameter int unsigned block_size_in_words_p = 4,
   parameter int unsigned sets_p                = 8,
   parameter int unsigned ways_p                = 4,
   localparam int unsigned lg_ways_lp  = (ways_p > 1) ? $clog2(ways_p) : 1,
   localparam int unsigned lg_sets_lp  = (sets_p > 1) ? $clog2(sets_p) : 1,
   localparam int unsigned lg_block_lp =
      (block_size_in_words_p > 1) ? $clog2(block_size_in_words_p) : 1,
   localparam int unsigned data_mask_width_lp = word_width_p / 8,
   localparam int unsigned dmem_addr_width_lp = lg_ways_lp + lg_sets_lp + lg_block_lp
) (
   input  logic                          clk_i,
   input  logic                          reset_n_i,
   input  logic [1:0]                    dma_cmd_i,
   input  logic [addr_width_p-1:0]       dma_addr_i,
   input  logic [lg_ways_lp-1:0]         way_i,
   input  logic                          evict_v_i,
   output logic                          dma_done_o,
   output logic [addr_width_p:0]         dma_pkt_o,
   output logic                          dma_pkt_v_o,
   input  logic                          dma_pkt_yumi_i,
   input  logic [word_width_p-1:0]       dma_data_i,
   input  logic                          dma_data_v_i,
   output logic                          dma_data_ready_o,
   output logic [word_width_p-1:0]       dma_data_o,
   output logic                          dma_data_v_o,
   input  logic                          dma_data_yumi_i,
   output logic                          data_mem_v_o,
   output logic                          data_mem_w_o,
   output logic [dmem_addr_width_lp-1:0] data_mem_addr_o,
   output logic [word_width_p-1:0]       data_mem_data_o,
   output logic [data_mask_width_lp-1:0] data_mem_w_mask_o,
   input  logic [word_width_p-1:0]       data_mem_data_i
);

   localparam logic [1:0] CmdNop            = 2'd0;
   localparam logic [1:0] CmdSendRefillAddr = 2'd1;
   localparam logic [1:0] CmdSendEvictAddr  = 2'd2;
   localparam logic [1:0] CmdGetFillData    = 2'd3;

   // Index field sits just above the word and byte offsets of the line address.
   localparam int unsigned idx_lsb_lp =
      $clog2(block_size_in_words_p) + $clog2(data_mask_width_lp);
   localparam logic [lg_block_lp-1:0] LastWord = lg_block_lp'(block_size_in_words_p - 1);

   typedef enum logic [2:0] {
      StIdle, StSendPkt, StEvictRd, StEvictTx, StFill, StDone
   } state_e;

   state_e                    state_q, state_d;
   logic [lg_block_lp-1:0]    cnt_q, cnt_d;
   logic [lg_ways_lp-1:0]     way_q, way_d;
   logic [lg_sets_lp-1:0]     index_q, index_d;
   logic                      pend_q, pend_d;
   logic [addr_width_p-1:0]   addr_q, addr_d;
   logic                      wnr_q, wnr_d;
   logic [word_width_p-1:0]   data_q, data_d;
   logic                      tx_v_q, tx_v_d;
   logic [lg_sets_lp-1:0]     addr_idx;
   logic                      cnt_last;

   assign addr_idx   = dma_addr_i[idx_lsb_lp +: lg_sets_lp];
   assign cnt_last   = (cnt_q == LastWord);
   assign dma_pkt_o  = {wnr_q, addr_q};
   assign dma_data_o = data_q;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         way_q   <= '0;
         index_q <= '0;
         pend_q  <= 1'b0;
         addr_q  <= '0;
         wnr_q   <= 1'b0;
         data_q  <= '0;
         tx_v_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         way_q   <= way_d;
         index_q <= index_d;
         pend_q  <= pend_d;
         addr_q  <= addr_d;
         wnr_q   <= wnr_d;
         data_q  <= data_d;
         tx_v_q  <= tx_v_d;
      end
   end

   always_comb begin
      state_d           = state_q;
      cnt_d             = cnt_q;
      way_d             = way_q;
      index_d           = index_q;
      pend_d            = pend_q;
      addr_d            = addr_q;
      wnr_d             = wnr_q;
      data_d            = data_q;
      tx_v_d            = tx_v_q;
      dma_done_o        = 1'b0;
      dma_pkt_v_o       = 1'b0;
      dma_data_ready_o  = 1'b0;
      dma_data_v_o      = 1'b0;
      data_mem_v_o      = 1'b0;
      data_mem_w_o      = 1'b0;
      data_mem_addr_o   = {way_q, index_q, cnt_q};
      data_mem_data_o   = '0;
      data_mem_w_mask_o = '0;

      // The management unit may announce an eviction while idle or alongside our done pulse.
      if (evict_v_i && (state_q == StIdle || state_q == StDone)) begin
         way_d   = way_i;
         index_d = addr_idx;
         pend_d  = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (pend_q) begin
               state_d = StEvictRd;
               cnt_d   = '0;
            end else begin
               unique case (dma_cmd_i)
                  CmdSendRefillAddr, CmdSendEvictAddr: begin
                     addr_d  = dma_addr_i;
                     wnr_d   = (dma_cmd_i == CmdSendEvictAddr);
                     state_d = StSendPkt;
                  end
                  CmdGetFillData: begin
                     cnt_d   = '0;
                     state_d = StFill;
                  end
                  CmdNop: state_d = StIdle;
               endcase
            end
         end
         StSendPkt: begin
            dma_pkt_v_o = 1'b1;
            if (dma_pkt_yumi_i) state_d = StDone;
         end
         StEvictRd: begin
            data_mem_v_o = 1'b1;
            state_d      = StEvictTx;
         end
         StEvictTx: begin
            if (!tx_v_q) begin
               data_d = data_mem_data_i;
               tx_v_d = 1'b1;
            end else begin
               dma_data_v_o = 1'b1;
               if (dma_data_yumi_i) begin
                  tx_v_d = 1'b0;
                  if (cnt_last) begin
                     cnt_d   = '0;
                     pend_d  = 1'b0;
                     state_d = StDone;
                  end else begin
                     cnt_d   = cnt_q + 1'b1;
                     state_d = StEvictRd;
                  end
               end
            end
         end
         StFill: begin
            dma_data_ready_o = 1'b1;
            data_mem_addr_o  = {way_i, addr_idx, cnt_q};
            if (dma_data_v_i) begin
               data_mem_v_o      = 1'b1;
               data_mem_w_o      = 1'b1;
               data_mem_data_o   = dma_data_i;
               data_mem_w_mask_o = '1;
               if (cnt_last) begin
                  cnt_d   = '0;
                  state_d = StDone;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         StDone: begin
            dma_done_o = 1'b1;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_bsg_cache_nb_mgmt_dma.sv
// Self-checking bench: packet vector table, directed evict/fill/reset sequences and a
// randomized mix checked against a word-addressed reference copy of data_mem.
module tb_bsg_cache_nb_mgmt_dma;

   localparam logic [1:0] CMD_NOP    = 2'd0;
   localparam logic [1:0] CMD_REFILL = 2'd1;
   localparam logic [1:0] CMD_EVICT  = 2'd2;
   localparam logic [1:0] CMD_FILL   = 2'd3;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // ---------------- DUT 0: 4 words/line, 8 sets, 4 ways ----------------
   logic [1:0]  dma_cmd_i;
   logic [31:0] dma_addr_i;
   logic [1:0]  way_i;
   logic        evict_v_i, dma_done_o, dma_pkt_v_o, dma_pkt_yumi_i;
   logic [32:0] dma_pkt_o;
   logic [31:0] dma_data_i, dma_data_o, data_mem_data_o, mem_rdata;
   logic        dma_data_v_i, dma_data_ready_o, dma_data_v_o, dma_data_yumi_i;
   logic        data_mem_v_o, data_mem_w_o;
   logic [6:0]  data_mem_addr_o;
   logic [3:0]  data_mem_w_mask_o;

   bsg_cache_nb_mgmt_dma #(
      .addr_width_p(32), .word_width_p(32), .block_size_in_words_p(4), .sets_p(8), .ways_p(4)
   ) dut (
      .clk_i(clk), .reset_n_i(reset_n), .dma_cmd_i(dma_cmd_i), .dma_addr_i(dma_addr_i),
      .way_i(way_i), .evict_v_i(evict_v_i), .dma_done_o(dma_done_o), .dma_pkt_o(dma_pkt_o),
      .dma_pkt_v_o(dma_pkt_v_o), .dma_pkt_yumi_i(dma_pkt_yumi_i), .dma_data_i(dma_data_i),
      .dma_data_v_i(dma_data_v_i), .dma_data_ready_o(dma_data_ready_o),
      .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o),
      .dma_data_yumi_i(dma_data_yumi_i), .data_mem_v_o(data_mem_v_o),
      .data_mem_w_o(data_mem_w_o), .data_mem_addr_o(data_mem_addr_o),
      .data_mem_data_o(data_mem_data_o), .data_mem_w_mask_o(data_mem_w_mask_o),
      .data_mem_data_i(mem_rdata)
   );

   // ---------------- DUT 1: 1 word/line ----------------
   logic [1:0]  b_cmd;
   logic [31:0] b_addr;
   logic [1:0]  b_way;
   logic        b_evict_v, b_done, b_pkt_v, b_pkt_yumi;
   logic [32:0] b_pkt;
   logic [31:0] b_fill_data, b_ev_data, b_dmem_wdata, b_rdata;
   logic        b_fill_v, b_ready, b_ev_v, b_ev_yumi;
   logic        b_dmem_v, b_dmem_w;
   logic [5:0]  b_dmem_addr;
   logic [3:0]  b_dmem_mask;

   bsg_cache_nb_mgmt_dma #(
      .addr_width_p(32), .word_width_p(32), .block_size_in_words_p(1), .sets_p(8), .ways_p(4)
   ) dut1 (
      .clk_i(clk), .reset_n_i(reset_n), .dma_cmd_i(b_cmd), .dma_addr_i(b_addr),
      .way_i(b_way), .evict_v_i(b_evict_v), .dma_done_o(b_done), .dma_pkt_o(b_pkt),
      .dma_pkt_v_o(b_pkt_v), .dma_pkt_yumi_i(b_pkt_yumi), .dma_data_i(b_fill_data),
      .dma_data_v_i(b_fill_v), .dma_data_ready_o(b_ready), .dma_data_o(b_ev_data),
      .dma_data_v_o(b_ev_v), .dma_data_yumi_i(b_ev_yumi), .data_mem_v_o(b_dmem_v),
      .data_mem_w_o(b_dmem_w), .data_mem_addr_o(b_dmem_addr),
      .data_mem_data_o(b_dmem_wdata), .data_mem_w_mask_o(b_dmem_mask),
      .data_mem_data_i(b_rdata)
   );

   // data_mem models (1-cycle read latency) with a bench-side preload port.
   logic [31:0] mem [128];
   logic [31:0] mem1 [64];
   logic [31:0] ref_mem [128];
   logic        pre_we, b_pre_we;
   logic [6:0]  pre_addr;
   logic [5:0]  b_pre_addr;
   logic [31:0] pre_data;

   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (data_mem_v_o && data_mem_w_o)
         for (int b = 0; b < 4; b++)
            if (data_mem_w_mask_o[b]) mem[data_mem_addr_o][8*b +: 8] <= data_mem_data_o[8*b +: 8];
      if (data_mem_v_o && !data_mem_w_o) mem_rdata <= mem[data_mem_addr_o];
   end

   always @(posedge clk) begin
      if (b_pre_we) mem1[b_pre_addr] <= pre_data;
      else if (b_dmem_v && b_dmem_w)
         for (int b = 0; b < 4; b++)
            if (b_dmem_mask[b]) mem1[b_dmem_addr][8*b +: 8] <= b_dmem_wdata[8*b +: 8];
      if (b_dmem_v && !b_dmem_w) b_rdata <= mem1[b_dmem_addr];
   end

   // Word address of (way, set, word) in a 4-way, 8-set, 4-word/line cache.
   function automatic int ma(input int way, input int idx, input int word);
      return way * 32 + idx * 4 + word;
   endfunction

   // Set index of a byte address: 16-byte lines, 8 sets.
   function automatic int set_of(input logic [31:0] addr);
      return int'((addr / 32'd16) % 32'd8);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic preload(input int a, input logic [31:0] d);
      @(negedge clk);
      pre_we   = 1'b1;
      pre_addr = 7'(a);
      pre_data = d;
      ref_mem[a] = d;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   task automatic send_pkt(input logic [1:0] cmd, input logic [31:0] addr, input int delay,
                           input logic [32:0] exp, input bit chg);
      @(negedge clk);
      dma_cmd_i  = cmd;
      dma_addr_i = addr;
      #1 chk("pkt_v_in_idle", 64'(dma_pkt_v_o), 64'd0);
      for (int d = 0; d <= delay; d++) begin
         @(negedge clk);
         if (chg) begin
            dma_cmd_i  = CMD_FILL;
            dma_addr_i = ~addr;
         end
         #1;
         chk("pkt_v", 64'(dma_pkt_v_o), 64'd1);
         chk("pkt_stable", 64'(dma_pkt_o), 64'(exp));
         chk("pkt_no_early_done", 64'(dma_done_o), 64'd0);
         chk("pkt_ready_low", 64'(dma_data_ready_o), 64'd0);
         dma_pkt_yumi_i = (d == delay);
      end
      @(negedge clk);
      dma_pkt_yumi_i = 1'b0;
      #1 chk("pkt_done", 64'(dma_done_o), 64'd1);
      @(negedge clk);
      dma_cmd_i = CMD_NOP;
      #1;
      chk("pkt_done_one_cycle", 64'(dma_done_o), 64'd0);
      chk("pkt_v_after_done", 64'(dma_pkt_v_o), 64'd0);
   endtask

   task automatic run_evict(input int way, input logic [31:0] addr, input int stall_word,
                            input int stall_cycles);
      logic [31:0] got[$];
      int idx, reads, dones, cyc, stall;
      bit prev_last;
      idx = set_of(addr);
      reads = 0; dones = 0; cyc = 0; stall = stall_cycles; prev_last = 1'b0;
      @(negedge clk);
      evict_v_i  = 1'b1;
      way_i      = 2'(way);
      dma_addr_i = addr;
      @(negedge clk);
      evict_v_i  = 1'b0;
      way_i      = 2'(way + 1);
      dma_addr_i = 32'hFFFF_FFFF;
      while (dones == 0 && cyc < 200) begin
         #1;
         if (data_mem_v_o && !data_mem_w_o) begin
            chk("ev_rd_addr", 64'(data_mem_addr_o), 64'(ma(way, idx, reads)));
            reads++;
         end
         if (dma_done_o) begin
            dones++;
            chk("ev_done_after_last_yumi", 64'(prev_last), 64'd1);
         end
         dma_data_yumi_i = 1'b0;
         if (dma_data_v_o) begin
            if (got.size() == stall_word && stall > 0) begin
               stall--;
               chk("ev_stall_data", 64'(dma_data_o), 64'(ref_mem[ma(way, idx, got.size())]));
            end else begin
               dma_data_yumi_i = 1'b1;
               got.push_back(dma_data_o);
            end
         end
         prev_last = dma_data_yumi_i && (got.size() == 4);
         @(negedge clk);
         dma_data_yumi_i = 1'b0;
         cyc++;
      end
      #1;
      chk("ev_single_done", 64'(dma_done_o), 64'd0);
      chk("ev_done_count", 64'(dones), 64'd1);
      chk("ev_read_count", 64'(reads), 64'd4);
      chk("ev_word_count", 64'(got.size()), 64'd4);
      for (int k = 0; k < 4 && k < got.size(); k++)
         chk("ev_word", 64'(got[k]), 64'(ref_mem[ma(way, idx, k)]));
   endtask

   task automatic run_fill(input int way, input logic [31:0] addr, input logic [31:0] w0,
                           input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3,
                           input logic [15:0] pat, input int plen);
      logic [31:0] wd[4];
      int idx, n, pc, cyc, dones;
      bit prev_last;
      wd = '{w0, w1, w2, w3};
      idx = set_of(addr);
      n = 0; pc = 0; cyc = 0; dones = 0; prev_last = 1'b0;
      @(negedge clk);
      dma_cmd_i  = CMD_FILL;
      way_i      = 2'(way);
      dma_addr_i = addr;
      while (dones == 0 && cyc < 100) begin
         #1;
         if (dma_done_o) begin
            dones++;
            chk("fill_done_after_last", 64'(prev_last), 64'd1);
         end
         prev_last = 1'b0;
         if (dma_data_ready_o && n < 4) begin
            dma_data_v_i = (pc < plen) ? pat[pc] : 1'b1;
            pc++;
         end else dma_data_v_i = 1'b0;
         dma_data_i = wd[n % 4];
         #1;
         if (dma_data_v_i && dma_data_ready_o) begin
            chk("fill_wr_en", 64'({data_mem_v_o, data_mem_w_o}), 64'd3);
            chk("fill_wr_addr", 64'(data_mem_addr_o), 64'(ma(way, idx, n)));
            chk("fill_wr_mask", 64'(data_mem_w_mask_o), 64'hF);
            chk("fill_wr_data", 64'(data_mem_data_o), 64'(wd[n]));
            ref_mem[ma(way, idx, n)] = wd[n];
            n++;
            prev_last = (n == 4);
         end else chk("fill_no_write", 64'(data_mem_v_o), 64'd0);
         @(negedge clk);
         cyc++;
      end
      dma_cmd_i    = CMD_NOP;
      dma_data_v_i = 1'b0;
      #1;
      chk("fill_single_done", 64'(dma_done_o), 64'd0);
      chk("fill_ready_idle", 64'(dma_data_ready_o), 64'd0);
      chk("fill_done_count", 64'(dones), 64'd1);
      chk("fill_word_count", 64'(n), 64'd4);
      for (int k = 0; k < 4; k++)
         chk("fill_mem", 64'(mem[ma(way, idx, k)]), 64'(ref_mem[ma(way, idx, k)]));
   endtask

   typedef struct {
      logic [1:0]  cmd;
      logic [31:0] addr;
      int          delay;
      bit          chg;
      logic [32:0] exp_pkt;
   } pkt_vec_t;

   pkt_vec_t vecs[4];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int way, idx, n, cyc, dones, reads;
      logic [31:0] addr;

      vecs[0] = '{CMD_REFILL, 32'h0000_1040, 3, 1'b0, {1'b0, 32'h0000_1040}};
      vecs[1] = '{CMD_EVICT,  32'h0000_2050, 0, 1'b0, {1'b1, 32'h0000_2050}};
      vecs[2] = '{CMD_REFILL, 32'hFFFF_FFC0, 1, 1'b1, {1'b0, 32'hFFFF_FFC0}};
      vecs[3] = '{CMD_EVICT,  32'h8000_0070, 5, 1'b1, {1'b1, 32'h8000_0070}};

      dma_cmd_i = CMD_NOP; dma_addr_i = '0; way_i = '0; evict_v_i = 1'b0;
      dma_pkt_yumi_i = 1'b0; dma_data_i = '0; dma_data_v_i = 1'b0; dma_data_yumi_i = 1'b0;
      b_cmd = CMD_NOP; b_addr = '0; b_way = '0; b_evict_v = 1'b0; b_pkt_yumi = 1'b0;
      b_fill_data = '0; b_fill_v = 1'b0; b_ev_yumi = 1'b0;
      pre_we = 1'b0; b_pre_we = 1'b0; pre_addr = '0; b_pre_addr = '0; pre_data = '0;

      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      chk("rst_done", 64'(dma_done_o), 64'd0);
      chk("rst_pkt_v", 64'(dma_pkt_v_o), 64'd0);
      chk("rst_pkt", 64'(dma_pkt_o), 64'd0);
      chk("rst_data_v", 64'(dma_data_v_o), 64'd0);
      chk("rst_data", 64'(dma_data_o), 64'd0);
      chk("rst_ready", 64'(dma_data_ready_o), 64'd0);
      chk("rst_dmem", 64'({data_mem_v_o, data_mem_w_o, data_mem_w_mask_o}), 64'd0);
      chk("rst_dmem_addr", 64'(data_mem_addr_o), 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      for (int a = 0; a < 128; a++) preload(a, $urandom());
      for (int k = 0; k < 4; k++) preload(ma(2, 5, k), 32'hA0A0_0000 + 32'(k));

      // Packet vectors
      for (int i = 0; i < 4; i++)
         send_pkt(vecs[i].cmd, vecs[i].addr, vecs[i].delay, vecs[i].exp_pkt, vecs[i].chg);

      // Evict way 2, index 5, words A..D
      send_pkt(CMD_EVICT, 32'h0000_2050, 1, {1'b1, 32'h0000_2050}, 1'b0);
      run_evict(2, 32'h0000_2050, 4, 0);

      // Fill way 1 with gaps 1,0,1,1,0,1
      run_fill(1, 32'h0000_3030, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
               32'h4444_4444, 16'b10_1101, 6);

      // Evict backpressure: 10 stalled cycles on word 2
      send_pkt(CMD_EVICT, 32'h0000_0070, 0, {1'b1, 32'h0000_0070}, 1'b0);
      run_evict(3, 32'h0000_0070, 2, 10);

      // Reset after two fill words, then a fresh fill from word 0
      @(negedge clk);
      dma_cmd_i = CMD_FILL; way_i = 2'd0; dma_addr_i = 32'h0000_0020;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         dma_data_v_i = 1'b1;
         dma_data_i   = 32'hDEAD_0000 + 32'(k);
         #1 chk("rf_pre_addr", 64'(data_mem_addr_o), 64'(ma(0, 2, k)));
      end
      @(negedge clk);
      dma_data_v_i = 1'b0;
      #3 reset_n = 1'b0;
      #1;
      chk("rf_ready", 64'(dma_data_ready_o), 64'd0);
      chk("rf_done", 64'(dma_done_o), 64'd0);
      chk("rf_outs", 64'({dma_pkt_v_o, dma_data_v_o, data_mem_v_o, data_mem_w_o}), 64'd0);
      @(negedge clk);
      dma_cmd_i = CMD_NOP;
      @(negedge clk);
      reset_n = 1'b1;
      #1 chk("rf_no_done_after", 64'(dma_done_o), 64'd0);
      run_fill(0, 32'h0000_0020, 32'h5555_0000, 32'h5555_0001, 32'h5555_0002,
               32'h5555_0003, 16'h0, 0);

      // Randomized mix against the reference memory
      for (int it = 0; it < 16; it++) begin
         way  = int'($urandom_range(0, 3));
         idx  = int'($urandom_range(0, 7));
         addr = (32'($urandom()) & 32'hFFFF_FF80) | 32'(idx * 16);
         if ($urandom_range(0, 1) == 1) begin
            send_pkt(CMD_EVICT, addr, int'($urandom_range(0, 3)), {1'b1, addr}, 1'b0);
            run_evict(way, addr, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
         end else begin
            send_pkt(CMD_REFILL, addr, int'($urandom_range(0, 3)), {1'b0, addr}, 1'b0);
            run_fill(way, addr, $urandom(), $urandom(), $urandom(), $urandom(),
                     16'($urandom()), 8);
         end
      end

      // One word per line: evict way 3 index 2, then fill way 1 index 7
      @(negedge clk);
      b_pre_we = 1'b1; b_pre_addr = 6'(3 * 16 + 2 * 2); pre_data = 32'hCAFE_0001;
      @(negedge clk);
      b_pre_we = 1'b0;
      b_evict_v = 1'b1; b_way = 2'd3; b_addr = 32'h0000_0008;
      @(negedge clk);
      b_evict_v = 1'b0; b_way = 2'd0; b_addr = '0;
      n = 0; cyc = 0; dones = 0; reads = 0;
      while (dones == 0 && cyc < 30) begin
         #1;
         if (b_dmem_v && !b_dmem_w) begin
            chk("b_ev_addr", 64'(b_dmem_addr), 64'(3 * 16 + 2 * 2));
            reads++;
         end
         if (b_done) dones++;
         b_ev_yumi = b_ev_v;
         if (b_ev_v) begin
            chk("b_ev_data", 64'(b_ev_data), 64'hCAFE_0001);
            n++;
         end
         @(negedge clk);
         b_ev_yumi = 1'b0;
         cyc++;
      end
      #1 chk("b_ev_single_done", 64'(b_done), 64'd0);
      chk("b_ev_counts", 64'({8'(n), 8'(reads), 8'(dones)}), 64'h01_01_01);

      @(negedge clk);
      b_cmd = CMD_FILL; b_way = 2'd1; b_addr = 32'h0000_001C;
      b_fill_v = 1'b1; b_fill_data = 32'h1234_5678;
      n = 0; cyc = 0; dones = 0;
      while (dones == 0 && cyc < 30) begin
         #1;
         if (b_done) dones++;
         if (b_ready && b_fill_v) begin
            chk("b_fill_addr", 64'(b_dmem_addr), 64'(1 * 16 + 7 * 2));
            chk("b_fill_mask", 64'(b_dmem_mask), 64'hF);
            n++;
         end
         @(negedge clk);
         cyc++;
      end
      b_cmd = CMD_NOP; b_fill_v = 1'b0;
      #1 chk("b_fill_single_done", 64'(b_done), 64'd0);
      chk("b_fill_counts", 64'({8'(n), 8'(dones)}), 64'h01_01);
      chk("b_fill_mem", 64'(mem1[1 * 16 + 7 * 2]), 64'h1234_5678);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
